// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register word width, snoop FIFO depth and the
// register word type used by the register-snoop logic.
package cpu_pkg;

   localparam int REG_W       = 16;
   localparam int SNOOP_DEPTH = 4;

   typedef logic [REG_W-1:0] reg_word_t;

endpackage : cpu_pkg

// File: rtl/reg_snoop_mem.sv
// DEPTH x DATA_W storage for the register snoop FIFO: one synchronous write
// port, one asynchronous read port, no reset on the array.
module reg_snoop_mem #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int PW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [PW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [PW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule : reg_snoop_mem

// File: rtl/reg_snoop_fifo.sv
// Captures every register load and replays the words in order over valid/ready.
// Optional sticky drop flag enabled by macro REG_SNOOP_FIFO_OVF_EN.
module reg_snoop_fifo
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int DEPTH  = SNOOP_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_in,
   input  logic [DATA_W-1:0]          data_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              push_s, pop_s, drop_s, full_s, empty_s;
   logic [DATA_W-1:0] rd_data_s;

   // handshake decode, pointer/count/overflow next state
   always_comb begin
      full_s   = (count_q == CW'(DEPTH));
      empty_s  = (count_q == {CW{1'b0}});
      pop_s    = out_ready && !empty_s;
      push_s   = load_in && (!full_s || pop_s);
      drop_s   = load_in && full_s && !pop_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      ovf_d    = 1'b0;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
`ifdef REG_SNOOP_FIFO_OVF_EN
      // a drop at the same edge as a clear keeps the flag set
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
`else
      ovf_d = 1'b0;
`endif
   end

`ifndef REG_SNOOP_FIFO_OVF_EN
   logic unused_ovf_clr_s;
   assign unused_ovf_clr_s = ovf_clr;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   reg_snoop_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PW     (PW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_s),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data_s)
   );

   // empty FIFO presents zero, so stale or unwritten storage never leaks out
   assign out_valid = !empty_s;
   assign out_data  = out_valid ? rd_data_s : {DATA_W{1'b0}};
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule : reg_snoop_fifo

// File: tb/tb_reg_snoop_fifo.sv
// Self-checking bench for reg_snoop_fifo: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_reg_snoop_fifo;
   import cpu_pkg::*;

   localparam int DEPTH = SNOOP_DEPTH;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            load_in = 1'b0;
   reg_word_t       data_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   reg_word_t       out_data;
   logic [CW-1:0]   count;
   logic            overflow;
   logic            ovf_clr = 1'b0;

   int        n_checks = 0;
   int        n_fail   = 0;
   reg_word_t mq[$];
   logic      m_ovf = 1'b0;

   always #5 clk = ~clk;

   reg_snoop_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .load_in   (load_in),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   // apply inputs for one edge, advance the model, then compare after the edge
   task automatic step(input logic ld, input reg_word_t d, input logic rdy, input logic clr);
      int  sz;
      bit  do_pop;
      load_in = ld; data_in = d; out_ready = rdy; ovf_clr = clr;
      sz = mq.size();
      do_pop = rdy && (sz > 0);
      if (do_pop) void'(mq.pop_front());
      if (ld && (sz < DEPTH || do_pop)) mq.push_back(d);
`ifdef REG_SNOOP_FIFO_OVF_EN
      if (ld && sz == DEPTH && !do_pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
`else
      m_ovf = 1'b0;
`endif
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic fill4();
      for (int i = 1; i <= 4; i++) step(1'b1, reg_word_t'(i), 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // single capture
      step(1'b1, 16'h00FE, 1'b0, 1'b0);
      chk("single_data", 32'(out_data), 32'h00FE);
      chk("single_cnt", 32'(count), 32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("single_empty", 32'(out_valid), 32'd0);

      // ordered burst, twice to wrap pointers
      for (int p = 0; p < 2; p++) begin
         fill4();
         chk("burst_cnt", 32'(count), 32'd4);
         for (int i = 1; i <= 4; i++) begin
            chk("burst_order", 32'(out_data), 32'(i));
            step(1'b0, 16'h0000, 1'b1, 1'b0);
         end
      end

      // full drop, then clear
      fill4();
      step(1'b1, 16'h0FE6, 1'b0, 1'b0);
      chk("drop_cnt", 32'(count), 32'd4);
      chk("drop_head", 32'(out_data), 32'h0001);
`ifdef REG_SNOOP_FIFO_OVF_EN
      chk("drop_ovf", 32'(overflow), 32'd1);
`else
      chk("drop_ovf", 32'(overflow), 32'd0);
`endif
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("ovf_clr", 32'(overflow), 32'd0);
      drain(4);

      // full push+pop
      fill4();
      step(1'b1, 16'h0FE6, 1'b1, 1'b0);
      chk("fpp_cnt", 32'(count), 32'd4);
      chk("fpp_ovf", 32'(overflow), 32'd0);
      drain(4);
      chk("fpp_valid", 32'(out_valid), 32'd0);

      // streaming: each word visible one cycle after capture
      for (int i = 0; i < 20; i++) begin
         step(1'b1, reg_word_t'(16'h0100 + i), 1'b1, 1'b0);
         chk("stream_data", 32'(out_data), 32'(16'h0100 + i));
      end
      chk("stream_cnt", 32'(count), 32'd1);
      drain(1);

      // reset mid-burst
      for (int i = 0; i < 3; i++) step(1'b1, reg_word_t'(16'h0050 + i), 1'b0, 1'b0);
      step(1'b1, 16'h0055, 1'b0, 1'b0);
      step(1'b1, 16'h0056, 1'b0, 1'b0);
      load_in = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_ovf", 32'(overflow), 32'd0);
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 16'h00AA, 1'b0, 1'b0);
      chk("post_rst_first", 32'(out_data), 32'h00AA);
      drain(1);

      // random traffic, alternating fill-heavy and drain-heavy phases
      for (int i = 0; i < 400; i++) begin
         int  ldp;
         logic ld, rdy, clr;
         ldp = ((i / 50) % 2 == 0) ? 75 : 30;
         ld  = ($urandom_range(0, 99) < ldp);
         rdy = ($urandom_range(0, 99) < (100 - ldp));
         clr = ($urandom_range(0, 15) == 0);
         step(ld, reg_word_t'($urandom), rdy, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule : tb_reg_snoop_fifo
